// File: rtl/ahb3lite_dma_scheduler_if.sv
// Bundle of requester, FIFO-status and AHB-master command signals for the DMA scheduler.
// Every strobe (o_gnt, o_done, o_err, o_NewCommandOn, i_Master_Done) is a one-cycle pulse with no back-pressure.
interface ahb3lite_dma_scheduler_if #(
  parameter int LEN_W = 6
);
  logic [1:0]       i_req;
  logic [LEN_W-1:0] i_len0;
  logic [LEN_W-1:0] i_len1;
  logic [31:0]      i_addr0;
  logic [31:0]      i_addr1;
  logic [5:0]       i_fifo_count;
  logic             i_Master_Done;
  logic [1:0]       o_gnt;
  logic [1:0]       o_done;
  logic [1:0]       o_err;
  logic             o_NewCommandOn;
  logic [LEN_W-1:0] o_RCC_BUFFER_LENGTH;
  logic [15:0]      o_RCC_DMA_ADDR_HIGH;
  logic [15:0]      o_RCC_DMA_ADDR_LOW;
  logic             o_busy;
  logic [1:0]       o_dbg_state;

  // master: the scheduler itself; slave: requesters, FIFO and AHB master around it
  modport master (
    input  i_req, i_len0, i_len1, i_addr0, i_addr1, i_fifo_count, i_Master_Done,
    output o_gnt, o_done, o_err, o_NewCommandOn, o_RCC_BUFFER_LENGTH,
           o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW, o_busy, o_dbg_state
  );

  modport slave (
    output i_req, i_len0, i_len1, i_addr0, i_addr1, i_fifo_count, i_Master_Done,
    input  o_gnt, o_done, o_err, o_NewCommandOn, o_RCC_BUFFER_LENGTH,
           o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW, o_busy, o_dbg_state
  );
endinterface

// File: rtl/ahb3lite_dma_scheduler.sv
// Two-requester round-robin DMA command scheduler in front of an AHB-Lite master.
// Issues a command only when the read FIFO has room for the whole buffer; aborts on a WAIT timeout.
module ahb3lite_dma_scheduler #(
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb3lite_dma_scheduler_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         CMP_W   = (LEN_W > 7) ? LEN_W : 7;
  localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);
  localparam logic [7:0] TOUT_C  = 8'(TIMEOUT);

  logic [1:0]       r_state;
  logic             r_ptr;
  logic             r_winner;
  logic             r_abort;
  logic [7:0]       r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_addr_hi;
  logic [15:0]      r_addr_lo;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic [1:0]       r_err;
  logic             r_newcmd;

  logic             w_win;
  logic [LEN_W-1:0] w_win_len;
  logic [31:0]      w_win_addr;
  logic [6:0]       w_space;
  logic             w_issue_ok;

  // On a tie the pointer names the requester that was not served last
  always_comb begin
    w_win = 1'b0;
    case (bus.i_req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = r_ptr;
      default: w_win = 1'b0;
    endcase
  end

  assign w_win_len  = w_win ? bus.i_len1  : bus.i_len0;
  assign w_win_addr = w_win ? bus.i_addr1 : bus.i_addr0;

  // An over-range occupancy reading counts as a full FIFO
  assign w_space    = ({1'b0, bus.i_fifo_count} > DEPTH_C) ? 7'd0
                                                           : DEPTH_C - {1'b0, bus.i_fifo_count};
  assign w_issue_ok = CMP_W'(w_space) >= CMP_W'(r_len);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_winner  <= 1'b0;
      r_abort   <= 1'b0;
      r_cnt     <= 8'd0;
      r_len     <= '0;
      r_addr_hi <= 16'd0;
      r_addr_lo <= 16'd0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      r_newcmd  <= 1'b0;
    end else begin
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_newcmd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_req != 2'b00) begin
            r_winner  <= w_win;
            r_len     <= w_win_len;
            r_addr_hi <= w_win_addr[31:16];
            r_addr_lo <= w_win_addr[15:0];
            r_gnt     <= {w_win, ~w_win};
            r_abort   <= 1'b0;
            r_state   <= (w_win_len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue_ok) begin
            r_newcmd <= 1'b1;
            r_cnt    <= 8'd0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // Completion is checked first so a same-cycle timeout never turns into an abort
          if (bus.i_Master_Done) begin
            r_state <= S_DONE;
          end else if (r_cnt == TOUT_C) begin
            r_abort <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_abort) r_err  <= {r_winner, ~r_winner};
          else         r_done <= {r_winner, ~r_winner};
          r_ptr   <= ~r_winner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_gnt               = r_gnt;
  assign bus.o_done              = r_done;
  assign bus.o_err               = r_err;
  assign bus.o_NewCommandOn      = r_newcmd;
  assign bus.o_RCC_BUFFER_LENGTH = r_len;
  assign bus.o_RCC_DMA_ADDR_HIGH = r_addr_hi;
  assign bus.o_RCC_DMA_ADDR_LOW  = r_addr_lo;
  assign bus.o_busy              = (r_state != S_IDLE);
  assign bus.o_dbg_state         = r_state;
endmodule

// File: tb/tb_ahb3lite_dma_scheduler.sv
// Directed bench for ahb3lite_dma_scheduler: arbitration, FIFO-space stall, timeout, zero length, reset.
module tb_ahb3lite_dma_scheduler;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [1:0] exp_q[$];

  ahb3lite_dma_scheduler_if #(.LEN_W(6)) bus();

  ahb3lite_dma_scheduler #(.LEN_W(6), .FIFO_DEPTH(32), .TIMEOUT(255)) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = grant, 1 = NewCommandOn, 2 = done
  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && bus.o_gnt != 2'b00) ||
          (which == 1 && bus.o_NewCommandOn) ||
          (which == 2 && bus.o_done != 2'b00)) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic drive_idle();
    bus.i_req         = 2'b00;
    bus.i_len0        = 6'd0;
    bus.i_len1        = 6'd0;
    bus.i_addr0       = 32'd0;
    bus.i_addr1       = 32'd0;
    bus.i_fifo_count  = 6'd0;
    bus.i_Master_Done = 1'b0;
  endtask

  task automatic pulse_done();
    bus.i_Master_Done = 1'b1;
    tick();
    bus.i_Master_Done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.o_gnt), 32'h0);
    check({tag, "_done"},  32'(bus.o_done), 32'h0);
    check({tag, "_err"},   32'(bus.o_err), 32'h0);
    check({tag, "_new"},   32'(bus.o_NewCommandOn), 32'h0);
    check({tag, "_len"},   32'(bus.o_RCC_BUFFER_LENGTH), 32'h0);
    check({tag, "_hi"},    32'(bus.o_RCC_DMA_ADDR_HIGH), 32'h0);
    check({tag, "_lo"},    32'(bus.o_RCC_DMA_ADDR_LOW), 32'h0);
    check({tag, "_busy"},  32'(bus.o_busy), 32'h0);
    check({tag, "_state"}, 32'(bus.o_dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    bit         ok;
    logic [1:0] g;

    drive_idle();
    #12;
    check_all_zero("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // basic command, Master_Done three cycles after issue, late input changes ignored
    bus.i_req = 2'b01; bus.i_len0 = 6'd8; bus.i_addr0 = 32'h1234_5678;
    tick();
    check("t1_gnt",  32'(bus.o_gnt), 32'h1);
    check("t1_hi",   32'(bus.o_RCC_DMA_ADDR_HIGH), 32'h1234);
    check("t1_lo",   32'(bus.o_RCC_DMA_ADDR_LOW), 32'h5678);
    check("t1_len",  32'(bus.o_RCC_BUFFER_LENGTH), 32'd8);
    check("t1_busy", 32'(bus.o_busy), 32'h1);
    bus.i_req = 2'b00; bus.i_len0 = 6'd33; bus.i_addr0 = 32'hDEAD_BEEF;
    tick();
    check("t1_new",   32'(bus.o_NewCommandOn), 32'h1);
    check("t1_gnt0",  32'(bus.o_gnt), 32'h0);
    check("t1_state", 32'(bus.o_dbg_state), 32'(S_WAIT));
    tick();
    check("t1_new_once", 32'(bus.o_NewCommandOn), 32'h0);
    pulse_done();
    check("t1_in_done", 32'(bus.o_dbg_state), 32'(S_DONE));
    check("t1_new_once2", 32'(bus.o_NewCommandOn), 32'h0);
    tick();
    check("t1_done",    32'(bus.o_done), 32'h1);
    check("t1_err",     32'(bus.o_err), 32'h0);
    check("t1_idle",    32'(bus.o_busy), 32'h0);
    check("t1_hi_hold", 32'(bus.o_RCC_DMA_ADDR_HIGH), 32'h1234);
    check("t1_len_hold", 32'(bus.o_RCC_BUFFER_LENGTH), 32'd8);
    tick();
    check("t1_done_pulse", 32'(bus.o_done), 32'h0);

    // round robin from a fresh reset with both requesters held high
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    bus.i_req = 2'b11; bus.i_len0 = 6'd1; bus.i_len1 = 6'd2;
    for (int c = 0; c < 3; c++) begin
      wait_for(0, 20, ok);
      check("rr_gnt_seen", 32'(ok), 32'h1);
      g = exp_q.pop_front();
      check("rr_order", 32'(bus.o_gnt), 32'(g));
      wait_for(1, 20, ok);
      check("rr_new_seen", 32'(ok), 32'h1);
      pulse_done();
      wait_for(2, 20, ok);
      check("rr_done_seen", 32'(ok), 32'h1);
      check("rr_done", 32'(bus.o_done), 32'(g));
      if (c == 2) bus.i_req = 2'b00;
    end
    tick();

    // FIFO-space stall: 20 words need count <= 12; over-range count means no space
    bus.i_req = 2'b01; bus.i_len0 = 6'd20; bus.i_fifo_count = 6'd20;
    tick();
    check("st_gnt", 32'(bus.o_gnt), 32'h1);
    bus.i_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_new20", 32'(bus.o_NewCommandOn), 32'h0);
    end
    bus.i_fifo_count = 6'd40;
    pulse_done();
    check("st_new40", 32'(bus.o_NewCommandOn), 32'h0);
    check("st_ignore_md", 32'(bus.o_dbg_state), 32'(S_ISSUE));
    bus.i_fifo_count = 6'd13;
    tick();
    check("st_new13", 32'(bus.o_NewCommandOn), 32'h0);
    bus.i_fifo_count = 6'd12;
    tick();
    check("st_new12", 32'(bus.o_NewCommandOn), 32'h1);
    pulse_done();
    tick();
    check("st_done", 32'(bus.o_done), 32'h1);
    bus.i_fifo_count = 6'd0;

    // timeout abort, then Master_Done in the timeout cycle
    bus.i_req = 2'b01; bus.i_len0 = 6'd4;
    tick();
    bus.i_req = 2'b00;
    tick();
    check("to_new", 32'(bus.o_NewCommandOn), 32'h1);
    ticks(255);
    check("to_still_wait", 32'(bus.o_dbg_state), 32'(S_WAIT));
    check("to_no_err_yet", 32'(bus.o_err), 32'h0);
    tick();
    check("to_in_done", 32'(bus.o_dbg_state), 32'(S_DONE));
    tick();
    check("to_err",  32'(bus.o_err), 32'h1);
    check("to_done", 32'(bus.o_done), 32'h0);
    bus.i_req = 2'b01;
    tick();
    bus.i_req = 2'b00;
    tick();
    check("tie_new", 32'(bus.o_NewCommandOn), 32'h1);
    ticks(255);
    pulse_done();
    check("tie_in_done", 32'(bus.o_dbg_state), 32'(S_DONE));
    tick();
    check("tie_done", 32'(bus.o_done), 32'h1);
    check("tie_err",  32'(bus.o_err), 32'h0);

    // zero length goes straight to DONE
    bus.i_req = 2'b01; bus.i_len0 = 6'd0;
    tick();
    check("z_gnt",   32'(bus.o_gnt), 32'h1);
    check("z_state", 32'(bus.o_dbg_state), 32'(S_DONE));
    check("z_new",   32'(bus.o_NewCommandOn), 32'h0);
    bus.i_req = 2'b00;
    tick();
    check("z_done", 32'(bus.o_done), 32'h1);
    check("z_new2", 32'(bus.o_NewCommandOn), 32'h0);

    // minimum IDLE-to-IDLE latency
    bus.i_req = 2'b01; bus.i_len0 = 6'd3;
    tick();
    bus.i_req = 2'b00;
    tick();
    check("lat_new", 32'(bus.o_NewCommandOn), 32'h1);
    pulse_done();
    tick();
    check("lat_idle", 32'(bus.o_dbg_state), 32'(S_IDLE));
    check("lat_done", 32'(bus.o_done), 32'h1);

    // asynchronous reset during WAIT, pointer back to requester 0
    bus.i_req = 2'b10; bus.i_len1 = 6'd5; bus.i_addr1 = 32'hA5A5_0F0F;
    tick();
    check("ar_gnt1", 32'(bus.o_gnt), 32'h2);
    bus.i_req = 2'b00;
    ticks(2);
    check("ar_wait", 32'(bus.o_dbg_state), 32'(S_WAIT));
    #2 rst_n = 1'b0;
    #1 check_all_zero("ar");
    bus.i_Master_Done = 1'b1;
    tick();
    check("ar_hold_done", 32'(bus.o_done), 32'h0);
    bus.i_Master_Done = 1'b0;
    bus.i_req = 2'b11; bus.i_len0 = 6'd2;
    #1 rst_n = 1'b1;
    tick();
    check("ar_gnt_ptr0", 32'(bus.o_gnt), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("ar2_gnt", 32'(bus.o_gnt), 32'h0);
    bus.i_req = 2'b10;
    tick();
    #1 rst_n = 1'b1;
    tick();
    check("ar_gnt_req1", 32'(bus.o_gnt), 32'h2);
    bus.i_req = 2'b00;
    wait_for(1, 20, ok);
    check("ar_new_seen", 32'(ok), 32'h1);
    pulse_done();
    wait_for(2, 20, ok);
    check("ar_done_seen", 32'(ok), 32'h1);
    check("ar_done", 32'(bus.o_done), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
